// File: rtl/tt4_pkg.sv
// Shared types and constants for the 4-input truth-table checker.
package tt4_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    localparam int unsigned NumVectors = 16;

endpackage

// File: rtl/tt4_checker.sv
// Exhaustive 16-vector checker for a 4-input cell: drives each vector, lets it
// settle, samples zn and tallies mismatches against a latched truth table.
module tt4_checker
    import tt4_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        zn,
    output logic        a1,
    output logic        a2,
    output logic        a3,
    output logic        a4,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  fail_idx,
    output logic        fail_vld
);

    localparam logic [3:0] LastIdx = 4'(NumVectors - 1);
    localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  fail_idx_q, fail_idx_d;
    logic        fail_vld_q, fail_vld_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        err_d      = err_q;
        fail_idx_d = fail_idx_q;
        fail_vld_d = fail_vld_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    exp_d      = expected;
                    err_d      = 5'd0;
                    fail_idx_d = 4'd0;
                    fail_vld_d = 1'b0;
                    idx_d      = 4'd0;
                    cnt_d      = 4'd0;
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = 4'd0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                if (zn != exp_q[idx_q]) begin
                    err_d = err_q + 5'd1;
                    // Only the first mismatch of a run is recorded.
                    if (!fail_vld_q) begin
                        fail_idx_d = idx_q;
                        fail_vld_d = 1'b1;
                    end
                end
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            cnt_q      <= 4'd0;
            exp_q      <= 16'd0;
            err_q      <= 5'd0;
            fail_idx_q <= 4'd0;
            fail_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
            fail_idx_q <= fail_idx_d;
            fail_vld_q <= fail_vld_d;
        end
    end

    // The index stays at 15 after the last sample, so DONE holds vector 1111.
    assign {a1, a2, a3, a4} = (state_q == StIdle) ? 4'b0000 : idx_q;
    assign busy      = (state_q == StDrive) || (state_q == StSample);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == 5'd0);
    assign err_count = err_q;
    assign fail_idx  = fail_idx_q;
    assign fail_vld  = fail_vld_q;

endmodule

// File: tb/tb_tt4_checker.sv
// Bench for tt4_checker: directed scenarios plus random truth tables and cell
// responses, checked against a per-vector mismatch model.
module tb_tt4_checker;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic        zn;
    logic        a1, a2, a3, a4;
    logic        busy, done, pass, fail_vld;
    logic [4:0]  err_count;
    logic [3:0]  fail_idx;
    logic [15:0] resp;

    int compared = 0;
    int mismatched = 0;

    tt4_checker #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .expected  (expected),
        .zn        (zn),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .a4        (a4),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_idx  (fail_idx),
        .fail_vld  (fail_vld)
    );

    always #5 clk = ~clk;

    // Cell under test: response table indexed by the driven vector.
    assign zn = resp[{a1, a2, a3, a4}];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_outs"}, {27'd0, a1, a2, a3, a4, busy},  32'd0);
        check({name, "_res"}, {22'd0, done, pass, err_count, fail_idx, fail_vld}, 32'd0);
    endtask

    task automatic check_results(input string name, input logic [15:0] e, input logic [15:0] r);
        int errs;
        int first;
        errs  = 0;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            if (e[i] != r[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_pass"}, {31'd0, pass}, (errs == 0) ? 32'd1 : 32'd0);
        check({name, "_errs"}, {27'd0, err_count}, errs);
        check({name, "_fvld"}, {31'd0, fail_vld}, (first >= 0) ? 32'd1 : 32'd0);
        check({name, "_fidx"}, {28'd0, fail_idx}, (first >= 0) ? first : 0);
        check({name, "_avec"}, {28'd0, a1, a2, a3, a4}, 32'hF);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Launch a run, optionally re-pulsing start with a zero table at vector 5.
    task automatic run(input string name, input logic [15:0] e, input logic [15:0] r,
                       input bit poke);
        int n;
        int bad;
        bit poked;
        logic [3:0] seen[$];
        poked = 0;
        bad   = 0;
        resp  = r;
        @(negedge clk);
        expected = e;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        expected = ~e;
        check({name, "_start"}, {30'd0, busy, done}, 32'b10);
        n = 1;
        while (!done && n < 400) begin
            if (busy) seen.push_back({a1, a2, a3, a4});
            if (poke && !poked && busy && {a1, a2, a3, a4} == 4'd5) begin
                start    = 1'b1;
                expected = 16'h0000;
                poked    = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, n, 16 * (S + 1) + 1);
        check({name, "_seqlen"}, seen.size(), 16 * (S + 1));
        foreach (seen[k]) if (seen[k] != 4'(k / (S + 1))) bad++;
        check({name, "_seq"}, bad, 0);
        check_results(name, e, r);
    endtask

    initial begin
        logic [15:0] re;
        logic [15:0] rr;
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        expected = 16'h0;
        resp     = 16'hFFFE;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run("or4_pass", 16'hFFFE, 16'hFFFE, 0);
        run("restart_done", 16'hFFFE, 16'hFFFE, 0);
        run("zn_tied0", 16'hFFFE, 16'h0000, 0);
        run("nor_table", 16'h0001, 16'hFFFE, 0);
        run("mid_start", 16'hFFFE, 16'hFFFE, 1);
        run("mid_start_err", 16'hF0FE, 16'hFFFE, 1);

        // Reset at vector 9 aborts the run.
        @(negedge clk);
        expected = 16'h1234;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while ({a1, a2, a3, a4} != 4'd9 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_vec9", {28'd0, a1, a2, a3, a4}, 32'd9);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("abort");
        repeat (3) @(posedge clk);
        #1;
        check_idle("abort_hold");
        run("after_abort", 16'hFFFE, 16'hFFFE, 0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        check_idle("rst_prio");

        for (int t = 0; t < 5; t++) begin
            re = 16'($urandom);
            rr = 16'($urandom);
            run("random", re, rr, ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tt4_checker.md
TT4_CHECKER -- requirements
Module: tt4_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of clock cycles a vector is held before ZN is sampled (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin an exhaustive run.
REQ-005 SHALL have port expected, input, 16, the expected-ZN truth table; bit i is the expected ZN for vector index i.
REQ-006 SHALL have port zn, input, 1, the response sampled from the cell under test.
REQ-007 SHALL have ports a1, a2, a3, a4, output, 1 each, driving the cell inputs.
REQ-008 SHALL have port busy, output, 1, high while a run is in progress.
REQ-009 SHALL have port done, output, 1, high from run completion until the next accepted start or reset.
REQ-010 SHALL have port pass, output, 1, valid when done is high; it is high iff err_count is 0.
REQ-011 SHALL have port err_count, output, 5, the number of mismatching vectors (0..16).
REQ-012 SHALL have port fail_idx, output, 4, the index of the first mismatching vector; fail_vld, output, 1, marks it valid.

Function
REQ-013 SHALL implement the states IDLE, DRIVE, SAMPLE, DONE.
REQ-014 SHALL, on start in IDLE or DONE, latch expected, clear err_count/fail_idx/fail_vld/done, set vector index to 0 and enter DRIVE on the next cycle.
REQ-015 SHALL ignore start while busy; the expected input is ignored except at acceptance.
REQ-016 SHALL map vector index i (i = 0..15) to a1=i[3], a2=i[2], a3=i[1], a4=i[0].
REQ-017 SHALL hold each vector in DRIVE for exactly SETTLE_CYCLES cycles, then spend 1 cycle in SAMPLE with the same vector still driven.
REQ-018 SHALL, in SAMPLE, compare zn to the latched expected[i]; on mismatch it increments err_count, and if fail_vld is low it sets fail_idx=i and fail_vld=1.
REQ-019 SHALL, after SAMPLE, go to DRIVE with i+1 if i<15, else go to DONE; the index never wraps within a run.
REQ-020 SHALL give a start-to-done latency of 16*(SETTLE_CYCLES+1)+1 cycles (done rises in the cycle after the SAMPLE of index 15).
REQ-021 SHALL assert busy in DRIVE and SAMPLE only; done in DONE only; pass = done AND (err_count==0).
REQ-022 SHALL drive a1..a4 to 0 in IDLE and hold the last vector (1111) in DONE.

Reset
REQ-023 SHALL, on rst_n=0 at a clock edge, enter IDLE with a1..a4=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0, fail_vld=0, and the settle counter and index at 0.
REQ-024 SHALL abort a run when reset is applied mid-run, discarding partial results; reset takes priority over a simultaneous start.

Structure
REQ-025 SHALL place the state encoding enum and the vector count constant (16) in the shared package tt4_pkg.
REQ-026 SHALL be a single module with no sub-modules; the cell under test is instantiated only in the bench.

Verification
REQ-027 SHALL cover: OR4_X2 DUT, expected=16'hFFFE, SETTLE_CYCLES=2 -> done at cycle 49 after start, pass=1, err_count=0, fail_vld=0.
REQ-028 SHALL cover: zn tied to 0, expected=16'hFFFE -> err_count=15, fail_idx=1, fail_vld=1, pass=0.
REQ-029 SHALL cover: OR4_X2 DUT, expected=16'h0001 (NOR table) -> err_count=16, fail_idx=0, pass=0.
REQ-030 SHALL cover: start pulsed again at vector 5 with expected=16'h0000 -> run unaffected, final results are those of the first expected value.
REQ-031 SHALL cover: rst_n low for 1 cycle at vector 9 -> next cycle IDLE, all outputs 0; a new start then completes normally.
REQ-032 SHALL cover: start asserted in DONE -> done drops the next cycle and a full 16-vector run repeats with fresh counters.
